sim_watchdog_mc: RTL

Multi-channel, parametrised watchdog and verdict engine for simulation harnesses.
- Each channel supervises one independent test thread with its own programmable timeout, kick (reload) input and completion input.
- The block aggregates per-channel outcomes into a single latched pass/fail verdict and a one-cycle finish pulse.
- It sits beside the testbench in the simulation top and is also synthesizable, so it can be used in on-board self-test.

---
 rtl/sim_watchdog_mc.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sim_watchdog_mc.sv
// Multi-channel watchdog: each channel runs an IDLE/RUN/DONE/EXPIRED machine with a
// reloadable down-counter, and the channel outcomes collapse into one latched pass/fail verdict.
module sim_watchdog_mc #(
    parameter int  CHANNELS        = 4,
    parameter int  CNT_W           = 16,
    parameter int  DEFAULT_TIMEOUT = 10000,
    parameter int  CYC_W           = 32,
    localparam int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [CNT_W-1:0]    cfg_timeout_i,
    input  logic [CHANNELS-1:0] en_i,
    input  logic [CHANNELS-1:0] start_i,
    input  logic [CHANNELS-1:0] kick_i,
    input  logic [CHANNELS-1:0] done_i,
    input  logic                clear_i,
    output logic [CHANNELS-1:0] active_o,
    output logic [CHANNELS-1:0] expired_o,
    output logic [CHANNELS-1:0] finished_o,
    output logic                finish_o,
    output logic                verdict_valid_o,
    output logic                verdict_pass_o,
    output logic [CYC_W-1:0]    cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_EXPIRED = 2'd3
    } chState_e;

    localparam logic [CNT_W-1:0] TMO_RST = CNT_W'(DEFAULT_TIMEOUT);

    chState_e         state_q [CHANNELS];
    chState_e         state_d [CHANNELS];
    logic [CNT_W-1:0] cnt_q   [CHANNELS];
    logic [CNT_W-1:0] cnt_d   [CHANNELS];
    logic [CNT_W-1:0] tmo_q   [CHANNELS];
    logic [CNT_W-1:0] tmo_d   [CHANNELS];

    logic             verdictValid_q, verdictValid_d;
    logic             verdictPass_q,  verdictPass_d;
    logic             finish_q,       finish_d;
    logic [CYC_W-1:0] cycles_q,       cycles_d;

    logic [CHANNELS-1:0] runVec;
    logic [CHANNELS-1:0] doneVec;
    logic [CHANNELS-1:0] expVec;
    logic                anyFail;
    logic                allPass;
    logic                latchNow;

    // Start outranks everything in the channel; inside RUN the order is done, kick, expiry.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            tmo_d[i]   = tmo_q[i];
            if (clear_i) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else if (start_i[i]) begin
                state_d[i] = ST_RUN;
                cnt_d[i]   = tmo_q[i];
            end else if (state_q[i] == ST_RUN) begin
                if (done_i[i]) begin
                    state_d[i] = ST_DONE;
                end else if (kick_i[i]) begin
                    cnt_d[i] = tmo_q[i];
                end else if (cnt_q[i] == '0) begin
                    state_d[i] = ST_EXPIRED;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
            if (cfg_we_i && (cfg_ch_i == CH_W'(i))) begin
                tmo_d[i] = cfg_timeout_i;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            runVec[i]  = (state_q[i] == ST_RUN);
            doneVec[i] = (state_q[i] == ST_DONE);
            expVec[i]  = (state_q[i] == ST_EXPIRED);
        end
    end

    assign anyFail  = |(en_i & expVec);
    assign allPass  = (en_i != '0) && ((en_i & ~doneVec) == '0);
    assign latchNow = !verdictValid_q && (anyFail || allPass);

    // Verdict looks at the registered channel states, so it trails them by one edge.
    always_comb begin
        verdictValid_d = verdictValid_q | latchNow;
        verdictPass_d  = latchNow ? !anyFail : verdictPass_q;
        finish_d       = latchNow;
        cycles_d       = (&cycles_q) ? cycles_q : cycles_q + CYC_W'(1);
        if (clear_i) begin
            verdictValid_d = 1'b0;
            verdictPass_d  = 1'b0;
            finish_d       = 1'b0;
            cycles_d       = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                tmo_q[i]   <= TMO_RST;
            end
            verdictValid_q <= 1'b0;
            verdictPass_q  <= 1'b0;
            finish_q       <= 1'b0;
            cycles_q       <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                tmo_q[i]   <= tmo_d[i];
            end
            verdictValid_q <= verdictValid_d;
            verdictPass_q  <= verdictPass_d;
            finish_q       <= finish_d;
            cycles_q       <= cycles_d;
        end
    end

    assign active_o        = runVec;
    assign expired_o       = expVec;
    assign finished_o      = doneVec;
    assign finish_o        = finish_q;
    assign verdict_valid_o = verdictValid_q;
    assign verdict_pass_o  = verdictPass_q;
    assign cycles_o        = cycles_q;

endmodule
